ahb2_cmd_master: RTL and testbench

- AHB2 (AHB-Lite) single-master bridge: converts a simple valid/ready command stream into pipelined AHB single transfers.
- Returns one response per completed transfer.
- Sits between test sequencers or DMA-style engines and AHB2 slaves such as the memory model.
- Supports back-to-back pipelined transfers, slave wait states, and error reporting.

---
 rtl/ahb2_cmd_master.sv | 138 +++++++++++++
 tb/tb_ahb2_cmd_master.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb2_cmd_master.sv
// AHB2 (AHB-Lite) single-master bridge: valid/ready command stream in, pipelined single transfers out.
// Optional wait-state watchdog enabled by defining AHB2_MST_TIMEOUT_EN.
module ahb2_cmd_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [31:0]           hwdata,
  input  logic [31:0]           hrdata,
  input  logic                  hready,
  input  logic                  hresp,
  output logic                  timeout_err
);

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  logic                  r_ap_valid;
  logic [ADDR_WIDTH-1:0] r_ap_addr;
  logic                  r_ap_write;
  logic [31:0]           r_ap_wdata;
  logic                  r_dp_valid;
  logic                  r_dp_write;
  logic [31:0]           r_dp_wdata;
  logic                  r_rsp_valid;
  logic                  r_rsp_write;
  logic [31:0]           r_rsp_rdata;
  logic                  r_rsp_err;

  logic w_accept;
  logic w_complete;
  logic w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^req_addr[1:0];

  assign req_ready  = !r_ap_valid | hready;
  assign w_accept   = req_valid & req_ready;
  assign w_complete = r_dp_valid & hready;

  // AP/DP pipeline: both stages move together on hready; a new command may refill AP on that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ap_valid <= 1'b0;
      r_ap_addr  <= '0;
      r_ap_write <= 1'b0;
      r_ap_wdata <= '0;
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_wdata <= '0;
    end else begin
      if (hready) begin
        r_dp_valid <= r_ap_valid;
        r_dp_write <= r_ap_write;
        // hwdata only changes when a write enters its data phase
        if (r_ap_valid && r_ap_write) begin
          r_dp_wdata <= r_ap_wdata;
        end
      end
      if (w_accept) begin
        r_ap_valid <= 1'b1;
        r_ap_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        r_ap_write <= req_write;
        r_ap_wdata <= req_wdata;
      end else if (hready) begin
        r_ap_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_complete;
      if (w_complete) begin
        r_rsp_write <= r_dp_write;
        r_rsp_rdata <= r_dp_write ? 32'h0 : hrdata;
        r_rsp_err   <= hresp;
      end
    end
  end

  assign htrans    = r_ap_valid ? HtransNonseq : HtransIdle;
  assign haddr     = r_ap_addr;
  assign hwrite    = r_ap_write;
  assign hsize     = 3'b010;
  assign hburst    = 3'b000;
  assign hwdata    = r_dp_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

`ifdef AHB2_MST_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_timeout;

  // Counts consecutive stalled cycles with work in flight; saturates so the flag cannot be missed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (hready) begin
      r_to_cnt <= '0;
    end else if (r_ap_valid || r_dp_valid) begin
      if (r_to_cnt != 16'hFFFF) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end
      if ((32'(r_to_cnt) + 32'd1) >= TIMEOUT_CYCLES) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ahb2_cmd_master.sv
// Self-checking bench for ahb2_cmd_master: AHB slave model with wait/error injection and a
// response scoreboard fed at command acceptance.
module tb_ahb2_cmd_master;

  localparam int unsigned AW = 32;
`ifdef AHB2_MST_TIMEOUT_EN
  localparam logic ExpTimeout = 1'b1;
`else
  localparam logic ExpTimeout = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_write, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize, hburst;
  logic [31:0]   hwdata, hrdata;
  logic          hready, hresp;
  logic          timeout_err;

  ahb2_cmd_master #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_write  (rsp_write),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hburst     (hburst),
    .hwdata     (hwdata),
    .hrdata     (hrdata),
    .hready     (hready),
    .hresp      (hresp),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Slave model: memory initialised to word index, wait states / ERROR injected by address.
  logic [31:0] mem [0:63];
  logic        s_dp_valid, s_dp_write, s_err, s_err2;
  logic [31:0] s_dp_addr;
  int          s_wait;
  logic        hold_low;
  logic [31:0] wait_addr, err_addr;
  int          wait_n;
  logic        err_en;

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = 32'h0;
    if (s_dp_valid) begin
      if (!s_dp_write) hrdata = s_err ? 32'hBAD0_BAD0 : mem[s_dp_addr[7:2]];
      if (s_wait > 0) begin
        hready = 1'b0;
      end else if (s_err) begin
        hresp  = 1'b1;
        hready = s_err2;
      end
    end
    if (hold_low) hready = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      s_dp_valid <= 1'b0;
      s_dp_write <= 1'b0;
      s_dp_addr  <= '0;
      s_wait     <= 0;
      s_err      <= 1'b0;
      s_err2     <= 1'b0;
      for (int i = 0; i < 64; i++) mem[i] <= i;
    end else if (hready) begin
      if (s_dp_valid && s_dp_write && !s_err) mem[s_dp_addr[7:2]] <= hwdata;
      s_dp_valid <= (htrans == 2'b10);
      s_dp_addr  <= haddr;
      s_dp_write <= hwrite;
      s_wait     <= (htrans == 2'b10 && haddr == wait_addr) ? wait_n : 0;
      s_err      <= err_en && (htrans == 2'b10) && (haddr == err_addr);
      s_err2     <= 1'b0;
    end else begin
      if (s_wait > 0) s_wait <= s_wait - 1;
      else if (s_err) s_err2 <= 1'b1;
    end
  end

  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic        err;
    logic        chk_rdata;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rsp_cnt = 0;
  int   run = 0;
  int   max_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (htrans == 2'b10) run++;
    else run = 0;
    if (run > max_run) max_run = run;
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (rsp_write !== mon_e.write) begin
          errors++;
          $display("FAIL rsp_write: got %b, required %b", rsp_write, mon_e.write);
        end
        checks++;
        if (rsp_err !== mon_e.err) begin
          errors++;
          $display("FAIL rsp_err: got %b, required %b", rsp_err, mon_e.err);
        end
        if (mon_e.chk_rdata) begin
          checks++;
          if (rsp_rdata !== mon_e.rdata) begin
            errors++;
            $display("FAIL rsp_rdata: got %h, required %h", rsp_rdata, mon_e.rdata);
          end
        end
        if (mon_e.lat > 0) begin
          checks++;
          if (cyc - mon_e.acc_cyc != mon_e.lat) begin
            errors++;
            $display("FAIL rsp_latency: got %0d, required %0d", cyc - mon_e.acc_cyc, mon_e.lat);
          end
        end
      end
    end
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic ee, input logic cr, input int lat);
    int   budget;
    logic acc;
    exp_t e;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    budget    = 100;
    acc       = 1'b0;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = req_ready;
      if (acc) begin
        e.write = w; e.rdata = er; e.err = ee; e.chk_rdata = cr; e.acc_cyc = cyc; e.lat = lat;
        exp_q.push_back(e);
      end
      @(posedge clk);
      budget--;
    end
    #1;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 for 100 cycles, required acceptance");
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic drain();
    int b;
    b = 200;
    while (exp_q.size() != 0 && b > 0) begin
      @(posedge clk);
      b--;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending responses, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hold_low = 1'b0; wait_addr = '1; wait_n = 0; err_addr = '1; err_en = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (htrans !== 2'b00 || haddr !== '0 || hwrite !== 1'b0 || hwdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_ahb: got htrans=%b haddr=%h hwrite=%b hwdata=%h, required 00/0/0/0",
               htrans, haddr, hwrite, hwdata);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_write !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: got v=%b w=%b d=%h e=%b, required all 0",
               rsp_valid, rsp_write, rsp_rdata, rsp_err);
    end
    checks++;
    if (timeout_err !== 1'b0 || req_ready !== 1'b1 || hsize !== 3'b010 || hburst !== 3'b000) begin
      errors++;
      $display("FAIL reset_misc: got to=%b rdy=%b hsize=%b hburst=%b, required 0/1/010/000",
               timeout_err, req_ready, hsize, hburst);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    max_run = 0;
    for (int i = 0; i < 8; i++) send(1'b0, 32'(i * 4), 32'h0, 32'(i), 1'b0, 1'b1, 3);
    idle();
    drain();
    checks++;
    if (max_run != 8) begin
      errors++;
      $display("FAIL b2b_nonseq_run: got %0d consecutive NONSEQ cycles, required 8", max_run);
    end
  endtask

  task automatic test_write_read();
    send(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 3);
    send(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 3);
    idle();
    drain();
  endtask

  task automatic test_wait_states();
    wait_addr = 32'h20;
    wait_n    = 3;
    send(1'b1, 32'h20, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 6);
    send(1'b0, 32'h24, 32'h0, 32'd9, 1'b0, 1'b1, 6);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (htrans !== 2'b10 || haddr !== 32'h24 || hwrite !== 1'b0) begin
        errors++;
        $display("FAIL wait_ap_hold: got htrans=%b haddr=%h hwrite=%b, required 10/24/0",
                 htrans, haddr, hwrite);
      end
      checks++;
      if (hwdata !== 32'h1234_5678) begin
        errors++;
        $display("FAIL wait_hwdata: got %h, required 12345678", hwdata);
      end
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL wait_req_ready: got %b, required 0", req_ready);
      end
    end
    wait_n = 0;
    drain();
  endtask

  task automatic test_error();
    err_addr = 32'h40;
    err_en   = 1'b1;
    send(1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1'b0, 4);
    send(1'b0, 32'h44, 32'h0, 32'd17, 1'b0, 1'b1, 4);
    idle();
    drain();
    err_en = 1'b0;
  endtask

  task automatic test_reset_abort();
    int snap;
    wait_addr = 32'h50;
    wait_n    = 10;
    send(1'b0, 32'h50, 32'h0, 32'd20, 1'b0, 1'b1, 0);
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    snap = rsp_cnt;
    @(posedge clk);
    #1;
    checks++;
    if (htrans !== 2'b00 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || haddr !== '0) begin
      errors++;
      $display("FAIL abort_state: got htrans=%b rdy=%b rsp_valid=%b haddr=%h, required 00/1/0/0",
               htrans, req_ready, rsp_valid, haddr);
    end
    rst_n  = 1'b1;
    wait_n = 0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (rsp_cnt != snap) begin
      errors++;
      $display("FAIL abort_no_rsp: got %0d responses, required 0", rsp_cnt - snap);
    end
  endtask

  task automatic test_timeout();
    hold_low = 1'b1;
    send(1'b0, 32'h60, 32'h0, 32'd24, 1'b0, 1'b1, 0);
    idle();
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got %b, required 0", timeout_err);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (timeout_err !== ExpTimeout) begin
      errors++;
      $display("FAIL timeout_set: got %b, required %b", timeout_err, ExpTimeout);
    end
    hold_low = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (timeout_err !== ExpTimeout) begin
      errors++;
      $display("FAIL timeout_sticky: got %b, required %b", timeout_err, ExpTimeout);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_write_read();
    test_wait_states();
    test_error();
    test_reset_abort();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

endmodule
